// File: rtl/telemetry_tx.sv
// -----------------------------------------------------------------------------
// telemetry_tx
//   Transmit side of the eBike telemetry link. A free-running period counter
//   produces a tick once every 2^PERIOD_W cycles. A tick seen while the
//   transmitter is idle snapshots batt/curr/torque and sends one fixed 8-byte
//   packet as back-to-back 8N1 UART frames:
//     AA 55 {0,batt[11:8]} batt[7:0] {0,curr[11:8]} curr[7:0]
//           {0,torque[11:8]} torque[7:0]
//   A tick that arrives while a packet is in flight is dropped.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   batt      in   [11:0] battery voltage reading
//   curr      in   [11:0] averaged motor current
//   torque    in   [11:0] averaged pedal torque
//   TX        out  UART serial line, idle high, driven from a flop
//   busy      out  high while a packet is being transmitted
//   pkt_done  out  one-cycle pulse in the last cycle of the final stop bit
//
// No valid/ready handshake: the inputs are sampled levels, captured only on
// the tick that starts a packet.
// -----------------------------------------------------------------------------
module telemetry_tx #(
  parameter int BAUD_DIV = 2604,
  parameter int PERIOD_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0]       BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]       BAUD_ONE  = BW'(1);
  localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [PERIOD_W-1:0] period_cnt;
  logic [BW-1:0]       baud_cnt, baud_cnt_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [2:0]          byte_idx, byte_idx_n;
  logic [7:0]          shift, shift_n;
  logic [35:0]         snap, snap_n;
  logic                tx_q, tx_n;
  logic                tick;
  logic                baud_last;

  // Byte n of the packet, built from the latched snapshot
  // ({batt, curr, torque} packed MSB first).
  function automatic logic [7:0] pkt_byte(input logic [2:0] idx,
                                          input logic [35:0] s);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hAA;
      3'd1:    b = 8'h55;
      3'd2:    b = {4'h0, s[35:32]};
      3'd3:    b = s[31:24];
      3'd4:    b = {4'h0, s[23:20]};
      3'd5:    b = s[19:12];
      3'd6:    b = {4'h0, s[11:8]};
      default: b = s[7:0];
    endcase
    return b;
  endfunction

  // Free-running period counter; tick on the all-ones count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PER_ONE;
    end
  end

  assign tick      = &period_cnt;
  assign baud_last = (baud_cnt == BAUD_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      snap     <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      shift    <= shift_n;
      snap     <= snap_n;
      tx_q     <= tx_n;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shift_n    = shift;
    snap_n     = snap;

    // Every non-idle state holds its line level for exactly BAUD_DIV cycles.
    if (state != ST_IDLE) begin
      baud_cnt_n = baud_last ? '0 : (baud_cnt + BAUD_ONE);
    end

    case (state)
      ST_IDLE: begin
        if (tick) begin
          state_n    = ST_START;
          snap_n     = {batt, curr, torque};
          byte_idx_n = 3'd0;
          bit_idx_n  = 3'd0;
          baud_cnt_n = '0;
          shift_n    = 8'hAA;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_n   = ST_DATA;
          bit_idx_n = 3'd0;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (byte_idx == 3'd7) begin
            state_n = ST_IDLE;
          end else begin
            // Next start bit follows immediately: no idle gap between bytes.
            state_n    = ST_START;
            byte_idx_n = byte_idx + 3'd1;
            shift_n    = pkt_byte(byte_idx + 3'd1, snap);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // TX is registered: compute the level the line must carry next cycle.
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  assign TX       = tx_q;
  assign busy     = (state != ST_IDLE);
  assign pkt_done = (state == ST_STOP) && baud_last && (byte_idx == 3'd7);

endmodule

// File: doc/telemetry_tx.md
Name: telemetry_tx

Overview:
- Transmit side of the eBike telemetry link.
- Periodically snapshots battery voltage, average motor current and average pedal torque (12-bit each).
- Frames the snapshot into a fixed 8-byte packet and serializes it as 8N1 UART on TX.
- Sits inside eBike, driving the top-level TX pin; the bench's UART_rcv is the far end.

Parameters:
- BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200 baud).
- PERIOD_W, 20, width of the free-running packet-period counter; tick every 2^PERIOD_W cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- batt  in  12  battery voltage reading
- curr  in  12  averaged motor current
- torque  in  12  averaged pedal torque
- TX  out  1  UART serial output, idle high
- busy  out  1  high while a packet is being transmitted
- pkt_done  out  1  one-cycle pulse at the end of the final stop bit

Behaviour:
- Reset (async, rst_n low):
  - TX=1, busy=0, pkt_done=0.
  - Period counter, baud counter, bit index and byte index cleared; FSM to IDLE.
- Period counter: PERIOD_W bits, free-running, increments every cycle, wraps.
  - tick is asserted in the cycle where count == all-ones.
  - First tick: cycle 2^PERIOD_W-1 after reset release.
- Packet start:
  - Occurs on tick while FSM is IDLE.
  - batt/curr/torque are latched into a 36-bit snapshot on the tick cycle.
  - busy=1 and TX=0 (start bit of byte 0) from the next cycle.
- Snapshot isolation: input changes after the tick do not affect the packet in flight.
- Overrun: a tick while busy=1 is dropped. No queuing; the next packet waits for the next tick seen while IDLE.
- Packet byte order:
  - B0=0xAA, B1=0x55
  - B2={4'h0,batt[11:8]}, B3=batt[7:0]
  - B4={4'h0,curr[11:8]}, B5=curr[7:0]
  - B6={4'h0,torque[11:8]}, B7=torque[7:0]
- Byte frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit held exactly BAUD_DIV cycles.
- Back-to-back bytes: start bit of byte n+1 begins the cycle after stop bit of byte n ends; no idle gap.
- Packet duration: exactly 80*BAUD_DIV cycles from first start-bit cycle to last stop-bit cycle inclusive.
- FSM states:
  - IDLE: TX=1; on tick -> START.
  - START: TX=0; after BAUD_DIV cycles -> DATA.
  - DATA: TX=shift[0]; shift right every BAUD_DIV cycles; after 8 bits -> STOP.
  - STOP: TX=1; after BAUD_DIV cycles -> START with next byte, or, if byte index==7, -> IDLE.
- End of packet:
  - pkt_done pulses in the last cycle of B7's stop bit.
  - busy deasserts the following cycle.
- Simultaneous tick and pkt_done cycle: the tick is dropped (FSM not yet IDLE).
- TX is driven from a flop (glitch-free).
- Reset mid-packet: TX returns to 1 immediately (async); the packet is abandoned, not resumed.

Test Plan:
- Reset check (BAUD_DIV=4, PERIOD_W=10): hold rst_n=0 -> TX=1, busy=0, pkt_done=0. Release -> first start bit at cycle 1024 after release.
- Content check: batt=0xB80, curr=0x123, torque=0x700 -> UART_rcv receives AA 55 0B 80 01 23 07 00 in order. pkt_done pulses once; busy high for exactly 320 cycles.
- Timing check (BAUD_DIV=4): every TX bit lasts exactly 4 cycles; byte-to-byte stop->start has no gap; data is LSB first (B0 line pattern 0,0,1,0,1,0,1,0,1,1).
- Snapshot isolation: change batt to 0x3FF one cycle after tick -> current packet still carries 0B 80; next packet carries 03 FF.
- Overrun drop (BAUD_DIV=4, PERIOD_W=8; packet 320 > period 256):
  - Packets start only on ticks seen while IDLE, i.e. every 512 cycles.
  - TX never shows a truncated or merged packet.
- Reset mid-packet: assert rst_n during B3 -> TX=1 and busy=0 in the same cycle. After release, a fresh complete packet starts 1024 cycles later (PERIOD_W=10).
